square_pixel_gen: RTL and testbench

Pixel source directly upstream of the VGA interface: consumes its `XCoord`/`YCoord` scan position and returns the 12-bit `pixel_color` for that position. It draws a solid square over a background with a one-pixel screen border. The square either bounces off the screen edges autonomously or is moved by buttons, and its position updates exactly once per frame, during vertical blanking.

---
 rtl/square_pixel_gen.sv | 124 ++++++++++++
 tb/tb_square_pixel_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/square_pixel_gen.sv
// Pixel source for the VGA scanner: draws a square over a bordered background.
// The square bounces or follows buttons, moving once per frame during blanking.
module square_pixel_gen #(
  parameter int unsigned SQ_SIZE      = 32,
  parameter int unsigned STEP         = 2,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'h00F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  XCoord,
  input  logic [9:0]  YCoord,
  input  logic        mode,
  input  logic        pause,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] pixel_color,
  output logic        frame_tick,
  output logic [9:0]  sq_x,
  output logic [9:0]  sq_y
);

  localparam int unsigned CW    = 10;
  localparam int unsigned SW    = 11;
  localparam int unsigned X_MAX = H_ACTIVE - SQ_SIZE;
  localparam int unsigned Y_MAX = V_ACTIVE - SQ_SIZE;

  localparam logic signed [SW-1:0] STEP_S  = SW'(STEP);
  localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);
  localparam logic signed [SW-1:0] ZERO_S  = SW'(0);

  // Returns {new_dir, new_pos}; reflects off 0 and lim.
  function automatic logic [CW:0] bounce_axis(input logic [CW-1:0] pos, input logic dir,
                                               input logic signed [SW-1:0] lim);
    logic signed [SW-1:0] nx;
    nx = dir ? ($signed({1'b0, pos}) + STEP_S) : ($signed({1'b0, pos}) - STEP_S);
    if (dir && (nx >= lim)) return {1'b0, lim[CW-1:0]};
    if (!dir && (nx <= ZERO_S)) return {1'b1, CW'(0)};
    return {dir, nx[CW-1:0]};
  endfunction

  // Opposing requests cancel; result is clamped to [0, lim].
  function automatic logic [CW-1:0] manual_axis(input logic [CW-1:0] pos, input logic inc,
                                                input logic dec, input logic signed [SW-1:0] lim);
    logic signed [SW-1:0] nx;
    nx = $signed({1'b0, pos});
    if (inc && !dec) nx = nx + STEP_S;
    else if (dec && !inc) nx = nx - STEP_S;
    if (nx < ZERO_S) return CW'(0);
    if (nx > lim) return lim[CW-1:0];
    return nx[CW-1:0];
  endfunction

  logic          f_prev;
  logic          dir_x, dir_y;
  logic          frame_c, tick_c;
  logic [CW-1:0] sq_x_nxt, sq_y_nxt;
  logic          dir_x_nxt, dir_y_nxt;
  logic [SW-1:0] x_end_c, y_end_c;
  logic          in_sq_c, offscreen_c, border_c;
  logic [11:0]   pix_c;

  // Frame boundary: first clock of column 0 on the first blanking row.
  assign frame_c = (XCoord == CW'(0)) && (YCoord == CW'(V_ACTIVE));
  assign tick_c  = frame_c && !f_prev;

  always_comb begin
    sq_x_nxt  = sq_x;
    sq_y_nxt  = sq_y;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    if (tick_c && !pause) begin
      if (mode) begin
        sq_x_nxt = manual_axis(sq_x, btn_right, btn_left, X_MAX_S);
        sq_y_nxt = manual_axis(sq_y, btn_down, btn_up, Y_MAX_S);
      end else begin
        {dir_x_nxt, sq_x_nxt} = bounce_axis(sq_x, dir_x, X_MAX_S);
        {dir_y_nxt, sq_y_nxt} = bounce_axis(sq_y, dir_y, Y_MAX_S);
      end
    end
  end

  assign x_end_c     = {1'b0, sq_x} + SW'(SQ_SIZE);
  assign y_end_c     = {1'b0, sq_y} + SW'(SQ_SIZE);
  assign offscreen_c = (XCoord >= CW'(H_ACTIVE)) || (YCoord >= CW'(V_ACTIVE));
  assign in_sq_c     = (XCoord >= sq_x) && ({1'b0, XCoord} < x_end_c) &&
                       (YCoord >= sq_y) && ({1'b0, YCoord} < y_end_c);
  assign border_c    = (XCoord == CW'(0)) || (XCoord == CW'(H_ACTIVE - 1)) ||
                       (YCoord == CW'(0)) || (YCoord == CW'(V_ACTIVE - 1));

  always_comb begin
    pix_c = BG_COLOR;
    if (offscreen_c)   pix_c = 12'h000;
    else if (in_sq_c)  pix_c = FG_COLOR;
    else if (border_c) pix_c = BORDER_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_color <= 12'h000;
      frame_tick  <= 1'b0;
      f_prev      <= 1'b0;
      sq_x        <= CW'(X_MAX / 2);
      sq_y        <= CW'(Y_MAX / 2);
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
    end else begin
      pixel_color <= pix_c;
      frame_tick  <= tick_c;
      f_prev      <= frame_c;
      sq_x        <= sq_x_nxt;
      sq_y        <= sq_y_nxt;
      dir_x       <= dir_x_nxt;
      dir_y       <= dir_y_nxt;
    end
  end

endmodule

// File: tb/tb_square_pixel_gen.sv
// Bench for square_pixel_gen: directed scenarios plus random frames, all
// compared every clock against an arithmetic model of the square's motion.
module tb_square_pixel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  xc, yc;
  logic        mode, pause, btn_up, btn_down, btn_left, btn_right;
  logic [11:0] pixel_color;
  logic        frame_tick;
  logic [9:0]  sq_x, sq_y;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  square_pixel_gen dut (
    .clk(clk), .rst(rst), .XCoord(xc), .YCoord(yc), .mode(mode), .pause(pause),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .pixel_color(pixel_color), .frame_tick(frame_tick), .sq_x(sq_x), .sq_y(sq_y)
  );

  // Reference model state
  bit model_on = 0;
  int m_x, m_y, m_dx, m_dy, m_fprev, exp_pix, exp_tick;
  bit m_f, m_tick;

  function automatic int colour(int x, int y, int sx, int sy);
    if (x >= 640 || y >= 480) return 0;
    if (x >= sx && x < sx + 32 && y >= sy && y < sy + 32) return 'hFFF;
    if (x == 0 || x == 639 || y == 0 || y == 479) return 'h00F;
    return 0;
  endfunction

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1;
      m_x = 304; m_y = 224; m_dx = 1; m_dy = 1;
      m_fprev = 0; exp_pix = 0; exp_tick = 0;
    end else if (model_on) begin
      m_f     = (xc == 0) && (yc == 480);
      m_tick  = m_f && (m_fprev == 0);
      exp_pix = colour(int'(xc), int'(yc), m_x, m_y);
      if (m_tick && !pause) begin
        if (mode) begin
          m_x = clampi(m_x + 2 * (int'(btn_right) - int'(btn_left)), 608);
          m_y = clampi(m_y + 2 * (int'(btn_down) - int'(btn_up)), 448);
        end else begin
          if (m_dx == 1) begin
            if (m_x + 2 >= 608) begin m_x = 608; m_dx = 0; end else m_x = m_x + 2;
          end else begin
            if (m_x - 2 <= 0) begin m_x = 0; m_dx = 1; end else m_x = m_x - 2;
          end
          if (m_dy == 1) begin
            if (m_y + 2 >= 448) begin m_y = 448; m_dy = 0; end else m_y = m_y + 2;
          end else begin
            if (m_y - 2 <= 0) begin m_y = 0; m_dy = 1; end else m_y = m_y - 2;
          end
        end
      end
      m_fprev  = int'(m_f);
      exp_tick = int'(m_tick);
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, expv, expv, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_on) begin
      chk("pixel_color", int'(pixel_color), exp_pix);
      chk("frame_tick", int'(frame_tick), exp_tick);
      chk("sq_x", int'(sq_x), m_x);
      chk("sq_y", int'(sq_y), m_y);
      if (frame_tick) tick_cnt++;
    end
  end

  task automatic px(input int x, input int y, input int expv, input string nm);
    xc = 10'(x); yc = 10'(y);
    @(negedge clk);
    chk(nm, int'(pixel_color), expv);
  endtask

  task automatic rand_xy();
    int x, y;
    if ($urandom_range(0, 1) == 0) begin
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 524);
    end else begin
      x = m_x + int'($urandom_range(0, 33)) - 1;
      y = m_y + int'($urandom_range(0, 33)) - 1;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
    end
    if (x == 0 && y == 480) x = 1;
    xc = 10'(x); yc = 10'(y);
    repeat (4) @(negedge clk);
  endtask

  task automatic frame();
    xc = 10'd0; yc = 10'd480;
    repeat (4) @(negedge clk);
    rand_xy();
    rand_xy();
  endtask

  initial begin
    int c0;
    rst = 1'b1; xc = 10'd100; yc = 10'd100;
    mode = 0; pause = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    repeat (2) @(negedge clk);
    chk("reset pixel", int'(pixel_color), 0);
    chk("reset sq_x", int'(sq_x), 304);
    chk("reset sq_y", int'(sq_y), 224);
    chk("reset tick", int'(frame_tick), 0);
    rst = 1'b0;

    px(320, 240, 'hFFF, "pix square centre");
    px(0, 0, 'h00F, "pix corner border");
    px(639, 100, 'h00F, "pix right border");
    px(640, 100, 'h000, "pix offscreen");
    px(100, 100, 'h000, "pix background");
    px(335, 255, 'hFFF, "pix square last");
    px(336, 255, 'h000, "pix past square");

    // Walk right manually to 604, then bounce off the right edge
    mode = 1; btn_right = 1;
    repeat (150) frame();
    chk("manual x to 604", int'(sq_x), 604);
    btn_right = 0; mode = 0;
    frame(); chk("bounce x 606", int'(sq_x), 606);
    frame(); chk("bounce x 608", int'(sq_x), 608);
    frame(); chk("bounce x back 606", int'(sq_x), 606);
    chk("bounce y 230", int'(sq_y), 230);

    // Set dir_y=0 at the bottom, walk up to 2, then bounce off the top
    mode = 1; btn_down = 1;
    repeat (110) frame();
    chk("manual y clamp 448", int'(sq_y), 448);
    btn_down = 0; mode = 0;
    frame(); chk("bounce y stays 448", int'(sq_y), 448);
    mode = 1; btn_up = 1;
    repeat (223) frame();
    chk("manual y to 2", int'(sq_y), 2);
    btn_up = 0; mode = 0;
    frame(); chk("bounce y 0", int'(sq_y), 0);
    frame(); chk("bounce y back 2", int'(sq_y), 2);
    chk("bounce x 600", int'(sq_x), 600);

    // Clamp at the left edge, cancelling buttons, pause
    mode = 1; btn_left = 1;
    repeat (302) frame();
    chk("manual x to 0", int'(sq_x), 0);
    frame(); chk("manual x stays 0", int'(sq_x), 0);
    btn_left = 0; btn_up = 1; btn_down = 1;
    repeat (3) frame();
    chk("cancel y", int'(sq_y), 2);
    btn_up = 0; btn_down = 0;
    pause = 1; mode = 0; btn_right = 1;
    repeat (3) frame();
    chk("pause x", int'(sq_x), 0);
    chk("pause y", int'(sq_y), 2);
    pause = 0; btn_right = 0;

    // One tick per 4-clock frame window
    c0 = tick_cnt;
    frame();
    chk("one tick per frame", tick_cnt - c0, 1);

    // Mid-frame reset, then release while F is still true
    xc = 10'd0; yc = 10'd480;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset sq_x", int'(sq_x), 304);
    chk("midreset sq_y", int'(sq_y), 224);
    chk("midreset pixel", int'(pixel_color), 0);
    chk("midreset tick", int'(frame_tick), 0);
    rst = 1'b0; mode = 1;
    @(negedge clk);
    chk("tick after reset in F", int'(frame_tick), 1);
    rand_xy();

    // Random frames
    repeat (300) begin
      mode      = 1'($urandom_range(0, 1));
      pause     = ($urandom_range(0, 7) == 0);
      btn_up    = 1'($urandom_range(0, 1));
      btn_down  = 1'($urandom_range(0, 1));
      btn_left  = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
